// File: rtl/puf_challenge_sequencer_if.sv
// Result channel of the PUF challenge sequencer: valid/ready handshake
// carrying {challenge, voted response}. With PUF_STABILITY_EN defined the
// channel also carries a per-bit "votes were not unanimous" flag.
interface puf_challenge_sequencer_if;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_challenge;
    logic [7:0] resp_data;
`ifdef PUF_STABILITY_EN
    logic [7:0] resp_unstable;
`endif

`ifdef PUF_STABILITY_EN
    modport master (output resp_valid, resp_challenge, resp_data, resp_unstable,
                    input  resp_ready);
    modport slave  (input  resp_valid, resp_challenge, resp_data, resp_unstable,
                    output resp_ready);
`else
    modport master (output resp_valid, resp_challenge, resp_data,
                    input  resp_ready);
    modport slave  (input  resp_valid, resp_challenge, resp_data,
                    output resp_ready);
`endif
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge/response sequencer.
// Walks an 8-bit LFSR challenge stream, launches VOTES measurements per
// challenge, majority-votes the synchronized responses and hands out
// {challenge, response} words over a valid/ready channel.
// Optional macro PUF_STABILITY_EN adds resp_unstable (non-unanimous bits).
module puf_challenge_sequencer #(
    parameter int SETTLE_CYC = 4,
    parameter int HOLD_CYC   = 4,
    parameter int VOTES      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] seed,
    input  logic [7:0] count,
    output logic       busy,
    output logic       done,
    output logic [7:0] puf_challenge,
    output logic       puf_pulse,
    input  logic [7:0] puf_response,
    puf_challenge_sequencer_if.master resp
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
    localparam logic [3:0] VOTES_LAST  = 4'(VOTES - 1);
    localparam logic [3:0] VOTES_HALF  = 4'(VOTES / 2);
`ifdef PUF_STABILITY_EN
    localparam logic [3:0] VOTES_ALL   = 4'(VOTES);
`endif

    typedef enum logic [2:0] {IDLE, SETUP, FIRE, RELAX, SAMPLE, OUTPUT} state_t;

    state_t          state;
    logic [7:0]      tmr;
    logic [3:0]      vcnt;
    logic [7:0]      remaining;
    logic [7:0]      lfsr;
    logic [7:0][3:0] cnt;
    logic [7:0]      sync1, sync2;
    logic [7:0]      lfsr_next;
    logic [7:0]      seed_eff;
    logic [7:0]      maj;
`ifdef PUF_STABILITY_EN
    logic [7:0]      unstable;
`endif

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign seed_eff  = (seed == 8'h00) ? 8'h01 : seed;

    // Per-bit majority (and unanimity) decision from the vote counters
    always_comb begin
        maj = '0;
`ifdef PUF_STABILITY_EN
        unstable = '0;
`endif
        for (int i = 0; i < 8; i++) begin
            maj[i] = cnt[i] > VOTES_HALF;
`ifdef PUF_STABILITY_EN
            unstable[i] = (cnt[i] != 4'd0) && (cnt[i] != VOTES_ALL);
`endif
        end
    end

    // Two-flop synchronizer for the asynchronous arbiter outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= puf_response;
            sync2 <= sync1;
        end
    end

    // Sequencer FSM: settle -> fire -> relax -> sample per vote, then output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            tmr                 <= '0;
            vcnt                <= '0;
            remaining           <= '0;
            lfsr                <= '0;
            cnt                 <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            puf_challenge       <= '0;
            puf_pulse           <= 1'b0;
            resp.resp_valid     <= 1'b0;
            resp.resp_challenge <= '0;
            resp.resp_data      <= '0;
`ifdef PUF_STABILITY_EN
            resp.resp_unstable  <= '0;
`endif
        end else begin
            done <= 1'b0;
            // abort wins over everything, including a same-cycle handshake
            if (abort && state != IDLE) begin
                state           <= IDLE;
                busy            <= 1'b0;
                puf_pulse       <= 1'b0;
                resp.resp_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (count == 8'd0) begin
                                done <= 1'b1;
                            end else begin
                                lfsr          <= seed_eff;
                                puf_challenge <= seed_eff;
                                remaining     <= count;
                                cnt           <= '0;
                                vcnt          <= '0;
                                tmr           <= '0;
                                busy          <= 1'b1;
                                state         <= SETUP;
                            end
                        end
                    end
                    SETUP: begin
                        if (tmr == SETTLE_LAST) begin
                            tmr       <= '0;
                            puf_pulse <= 1'b1;
                            state     <= FIRE;
                        end else begin
                            tmr <= tmr + 8'd1;
                        end
                    end
                    FIRE: begin
                        if (tmr == HOLD_LAST) begin
                            tmr       <= '0;
                            puf_pulse <= 1'b0;
                            state     <= RELAX;
                        end else begin
                            tmr <= tmr + 8'd1;
                        end
                    end
                    RELAX: begin
                        if (tmr == HOLD_LAST) begin
                            tmr   <= '0;
                            state <= SAMPLE;
                        end else begin
                            tmr <= tmr + 8'd1;
                        end
                    end
                    SAMPLE: begin
                        for (int i = 0; i < 8; i++)
                            cnt[i] <= cnt[i] + 4'(sync2[i]);
                        if (vcnt == VOTES_LAST) begin
                            vcnt  <= '0;
                            state <= OUTPUT;
                        end else begin
                            vcnt  <= vcnt + 4'd1;
                            state <= SETUP;
                        end
                    end
                    OUTPUT: begin
                        // first cycle registers the voted word (counters now
                        // include the last sample); it then holds until taken
                        if (!resp.resp_valid) begin
                            resp.resp_valid     <= 1'b1;
                            resp.resp_challenge <= lfsr;
                            resp.resp_data      <= maj;
`ifdef PUF_STABILITY_EN
                            resp.resp_unstable  <= unstable;
`endif
                        end else if (resp.resp_ready) begin
                            resp.resp_valid <= 1'b0;
                            remaining       <= remaining - 8'd1;
                            if (remaining == 8'd1) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                lfsr          <= lfsr_next;
                                puf_challenge <= lfsr_next;
                                cnt           <= '0;
                                state         <= SETUP;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer. The PUF is modelled as
// response = challenge ^ 8'hA5, optionally flipping bit0 on votes 2 and 4.
module tb_puf_challenge_sequencer;

    typedef struct packed {
        logic [7:0] chal;
        logic [7:0] data;
        logic [7:0] unst;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [7:0] count = 8'h00;
    logic       busy, done, puf_pulse;
    logic [7:0] puf_challenge, puf_response;

    puf_challenge_sequencer_if rif();

    puf_challenge_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .seed          (seed),
        .count         (count),
        .busy          (busy),
        .done          (done),
        .puf_challenge (puf_challenge),
        .puf_pulse     (puf_pulse),
        .puf_response  (puf_response),
        .resp          (rif)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    word_t exp_q[$];
    int    done_cnt = 0, busy_cnt = 0, valid_cnt = 0;

    // PUF model with optional bit0 noise on votes 2 and 4 of a challenge
    int   vote_idx = 0;
    int   vote_base = 0;
    logic noise = 1'b0;
    logic pulse_q = 1'b0;
    logic flip;

    always @(posedge clk) begin
        pulse_q <= puf_pulse;
        if (puf_pulse && !pulse_q) vote_idx <= vote_idx + 1;
    end

    always_comb begin
        flip = noise && ((vote_idx - vote_base) == 2 || (vote_idx - vote_base) == 4);
        puf_response = (puf_challenge ^ 8'hA5) ^ {7'b0, flip};
    end

    task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (rif.resp_valid) valid_cnt++;
            if (rif.resp_valid && rif.resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_word", {16'h0, rif.resp_challenge, rif.resp_data}, 32'h0);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk(rif.resp_challenge == e.chal, "resp_challenge", 32'(rif.resp_challenge), 32'(e.chal));
                    chk(rif.resp_data == e.data, "resp_data", 32'(rif.resp_data), 32'(e.data));
`ifdef PUF_STABILITY_EN
                    chk(rif.resp_unstable == e.unst, "resp_unstable", 32'(rif.resp_unstable), 32'(e.unst));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input logic [7:0] d, input logic [7:0] u);
        word_t w;
        w.chal = c; w.data = d; w.unst = u;
        exp_q.push_back(w);
    endtask

    // Pulse start for one sampling edge; returns right after that edge
    task automatic kick(input logic [7:0] s, input logic [7:0] n);
        seed = s; count = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!done && n < budget) begin tick(); n++; end
        chk(done, name, 32'(n), 32'(budget));
    endtask

    initial begin
        int n, d0, b0, v0;
        logic [7:0] hc, hd, hp;
        rif.resp_ready = 1'b1;

        // reset state
        #2;
        chk(busy == 0 && done == 0 && puf_pulse == 0 && puf_challenge == 0 && rif.resp_valid == 0,
            "reset_outputs", {busy, done, puf_pulse, rif.resp_valid}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // basic run, latency and done
        push(8'h01, 8'hA4, 8'h00);
        push(8'h02, 8'hA7, 8'h00);
        push(8'h04, 8'hA1, 8'h00);
        d0 = done_cnt;
        kick(8'h01, 8'd3);
        chk(busy, "busy_after_start", 32'(busy), 32'h1);
        n = 0;
        while (!rif.resp_valid && n < 200) begin tick(); n++; end
        chk(n == 66, "first_valid_latency", 32'(n), 32'd66);
        wait_done(200, "done_run3");
        tick();
        chk(busy == 0, "busy_after_done", 32'(busy), 32'h0);
        chk(done_cnt == d0 + 1, "done_pulses_run3", 32'(done_cnt - d0), 32'h1);

        // zero seed replaced by 01
        push(8'h01, 8'hA4, 8'h00);
        kick(8'h00, 8'd1);
        wait_done(200, "done_seed0");
        tick();

        // count 0: lone done pulse, nothing else
        d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
        kick(8'h5A, 8'd0);
        chk(done == 1 && busy == 0, "count0_done", {done, busy}, 32'h2);
        repeat (5) tick();
        chk(done_cnt == d0 + 1, "count0_done_once", 32'(done_cnt - d0), 32'h1);
        chk(busy_cnt == b0 && valid_cnt == v0, "count0_quiet", 32'(busy_cnt - b0 + valid_cnt - v0), 32'h0);

        // noisy bit0 on 2 of 5 votes
        vote_base = vote_idx;
        noise = 1'b1;
        push(8'h33, 8'h96, 8'h01);
        kick(8'h33, 8'd1);
        wait_done(200, "done_noise");
        noise = 1'b0;
        tick();

        // backpressure holds the word and the challenge
        rif.resp_ready = 1'b0;
        push(8'h10, 8'hB5, 8'h00);
        push(8'h21, 8'h84, 8'h00);
        kick(8'h10, 8'd2);
        n = 0;
        while (!rif.resp_valid && n < 200) begin tick(); n++; end
        chk(rif.resp_valid, "bp_valid_seen", 32'(n), 32'd200);
        hc = rif.resp_challenge; hd = rif.resp_data; hp = puf_challenge;
        chk(hc == 8'h10, "bp_held_challenge", 32'(hc), 32'h10);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk(rif.resp_valid && rif.resp_challenge == hc && rif.resp_data == hd && !puf_pulse && puf_challenge == hp,
                "bp_stable", {rif.resp_valid, puf_pulse, rif.resp_challenge, rif.resp_data, puf_challenge}, {2'b10, hc, hd, hp});
        end
        rif.resp_ready = 1'b1;
        wait_done(200, "done_bp");
        tick();

        // abort during FIRE
        n = 0;
        kick(8'h55, 8'd2);
        while (!puf_pulse && n < 50) begin tick(); n++; end
        chk(puf_pulse, "abort_reached_fire", 32'(n), 32'd50);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk(puf_pulse == 0 && busy == 0, "abort_stops", {puf_pulse, busy}, 32'h0);
        repeat (20) tick();
        chk(done_cnt == d0 && !rif.resp_valid && !busy, "abort_no_done", 32'(done_cnt - d0), 32'h0);
        push(8'h80, 8'h25, 8'h00);
        kick(8'h80, 8'd1);
        wait_done(200, "done_after_abort");
        tick();

        // async reset while firing
        kick(8'h07, 8'd1);
        n = 0;
        while (!puf_pulse && n < 50) begin tick(); n++; end
        chk(puf_pulse, "reset_reached_fire", 32'(n), 32'd50);
        #2 rst_n = 1'b0;
        #1;
        chk(busy == 0 && puf_pulse == 0 && puf_challenge == 0 && done == 0 && rif.resp_valid == 0,
            "async_reset", {busy, puf_pulse, done, rif.resp_valid, puf_challenge}, 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk(busy == 0 && puf_pulse == 0, "post_reset_idle", {busy, puf_pulse}, 32'h0);

        chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
- Sequences challenge/response measurements for the 8-bit arbiter-PUF array.
- Generates a challenge stream from an 8-bit LFSR seed, drives the challenge lines, fires launch pulses and samples the 8-bit response through a synchronizer.
- Majority-votes VOTES repeated measurements per challenge.
- Delivers {challenge, response} words over a valid/ready interface to the host-side logic in the top-level wrapper.

Parameters:
- SETTLE_CYC, 4: cycles the challenge is held stable with pulse low before launch (>=1).
- HOLD_CYC, 4: cycles the pulse stays high, and then low, before sampling (>=2).
- VOTES, 5: measurements per challenge; odd, 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a run; ignored while busy
- abort  in  1  synchronous run cancel
- seed  in  8  first challenge; 0 is replaced by 8'h01
- count  in  8  number of challenges in the run
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse at normal run completion
- puf_challenge  out  8  challenge bus to the PUF array
- puf_pulse  out  1  launch pulse to the PUF delay lines
- puf_response  in  8  asynchronous PUF arbiter outputs
- resp_valid  out  1  result word valid
- resp_ready  in  1  consumer accepts result
- resp_challenge  out  8  challenge of the current result
- resp_data  out  8  majority-voted response

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0, state IDLE, LFSR 0, vote counters 0, synchronizer flops 0.
- puf_response passes through a 2-flop synchronizer before any use.
- LFSR step: next = {c[6:0], c[7]^c[5]^c[4]^c[3]}.
- Per-bit vote counters are 4 bits wide. Majority rule: bit = 1 when counter > VOTES/2.
- States: IDLE, SETUP, FIRE, RELAX, SAMPLE, OUTPUT.
  - IDLE, start=1 and count!=0: latch challenge = (seed==0 ? 8'h01 : seed), remaining = count, clear counters, busy=1, go to SETUP.
  - IDLE, start=1 and count==0: done pulses the next cycle; busy stays 0; no resp_valid.
  - SETUP: puf_challenge = challenge, puf_pulse=0; lasts SETTLE_CYC cycles, then FIRE.
  - FIRE: puf_pulse=1 for HOLD_CYC cycles, then RELAX.
  - RELAX: puf_pulse=0 for HOLD_CYC cycles, then SAMPLE.
  - SAMPLE (1 cycle): add each synchronized response bit to its counter. If VOTES samples are done, go to OUTPUT; else go to SETUP.
  - OUTPUT: resp_valid=1, resp_challenge = challenge, resp_data = majority. Both values stay stable until resp_ready. puf_pulse stays 0.
  - OUTPUT handshake (resp_valid & resp_ready): decrement remaining. If remaining reaches 0: done pulses for 1 cycle, busy=0, go to IDLE. Otherwise step the LFSR, clear counters, go to SETUP.
- Latency: start sampled at edge k gives first resp_valid at edge k+1+VOTES*(SETTLE_CYC+2*HOLD_CYC+1). Defaults: k+66.
- abort in any non-IDLE state: next cycle IDLE, puf_pulse=0, resp_valid=0, busy=0, no done. Abort has priority over a same-cycle handshake.
- start while busy: ignored, no side effects.
- puf_challenge changes only on entry to SETUP, never while puf_pulse=1. It keeps its last value in IDLE.
- LFSR never reaches 0, because the seed is forced non-zero.

Optional Feature:
- Macro: PUF_STABILITY_EN.
- Defined: adds output resp_unstable [7:0], valid with resp_valid. A bit is 1 when its counter is neither 0 nor VOTES, i.e. the votes were not unanimous. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-FIRE -> all outputs 0 asynchronously; after release, busy=0 and puf_pulse=0.
- Ideal model resp = chal^8'hA5, seed 8'h01, count 3, resp_ready=1 -> words (01,A4), (02,A7), (04,A1). First resp_valid 66 cycles after start; done after the third handshake.
- seed 8'h00, count 1 -> resp_challenge 8'h01. Separately, start with count 0 -> single done pulse, busy never high, resp_valid never high.
- Noise: model flips bit0 on 2 of 5 votes -> resp_data equals the ideal value. With PUF_STABILITY_EN, resp_unstable = 8'h01; with no noise, 8'h00.
- Backpressure: resp_ready=0 for 10 cycles -> resp_valid, resp_challenge and resp_data stay stable, puf_pulse stays 0, no LFSR step.
- abort asserted during FIRE -> next cycle puf_pulse=0, busy=0, no done. A subsequent start runs normally from its own seed.
